// File: rtl/gate_vector_checker.sv
// gate_vector_checker: self-checking back end for the 3-bit gate block (y = {a&b, a|b, ~a}).
// Captures each applied vector, waits SETTLE cycles, compares y, and reports pass/fail after NVEC vectors.
`default_nettype none

module gate_vector_checker #(
  parameter int NVEC   = 4,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vld,
  input  logic             a,
  input  logic             b,
  input  logic [2:0]       y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_flag,
  output logic [1:0]       first_err_vec,
  output logic [2:0]       first_err_y
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0]       SETTLE_LD = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  localparam logic [CNT_W-1:0] NVEC_C    = CNT_W'(NVEC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state, state_next;
  logic             va, vb;
  logic [3:0]       settle_cnt;
  logic             clear, capture;
  logic [2:0]       exp_y;
  logic             mismatch;
  logic [CNT_W-1:0] vec_cnt_inc;

  assign exp_y       = {va & vb, va | vb, ~va};
  assign mismatch    = (y != exp_y);
  assign vec_cnt_inc = vec_cnt + CNT_ONE;

  always_comb begin
    state_next = state;
    clear      = 1'b0;
    capture    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          clear      = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (vld) begin
          capture    = 1'b1;
          state_next = (SETTLE == 0) ? S_CHECK : S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (settle_cnt == 4'd0) state_next = S_CHECK;
      end
      S_CHECK: begin
        busy       = 1'b1;
        state_next = (vec_cnt_inc == NVEC_C) ? S_DONE : S_RUN;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          clear      = 1'b1;
          state_next = S_RUN;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign pass = done && (err_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      va            <= 1'b0;
      vb            <= 1'b0;
      settle_cnt    <= 4'd0;
      vec_cnt       <= '0;
      err_cnt       <= '0;
      err_flag      <= 1'b0;
      first_err_vec <= 2'b00;
      first_err_y   <= 3'b000;
    end else begin
      state <= state_next;
      if (capture) begin
        va         <= a;
        vb         <= b;
        settle_cnt <= SETTLE_LD;
      end else if (state == S_WAIT && settle_cnt != 4'd0) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
      if (clear) begin
        vec_cnt       <= '0;
        err_cnt       <= '0;
        err_flag      <= 1'b0;
        first_err_vec <= 2'b00;
        first_err_y   <= 3'b000;
      end else if (state == S_CHECK) begin
        vec_cnt <= vec_cnt_inc;
        if (mismatch) begin
          // err_cnt saturates instead of wrapping so a long failing run never reads as clean
          if (err_cnt != '1) err_cnt <= err_cnt + CNT_ONE;
          if (!err_flag) begin
            first_err_vec <= {va, vb};
            first_err_y   <= y;
            err_flag      <= 1'b1;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gate_vector_checker.sv
// Directed bench for gate_vector_checker: three instances with SETTLE = 2, 0 and 3.
`default_nettype none

module tb_gate_vector_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic a = 1'b0, b = 1'b0;
  logic start = 1'b0, vld = 1'b0, stuck = 1'b0;
  logic start0 = 1'b0, vld0 = 1'b0;
  logic start3 = 1'b0, vld3 = 1'b0, glitch3 = 1'b0;

  logic [2:0] y, y0, y3;
  assign y  = {a & b & ~stuck, a | b, ~a};
  assign y0 = {a & b, a | b, ~a};
  assign y3 = glitch3 ? 3'b111 : {a & b, a | b, ~a};

  logic       busy, done, pass, err_flag;
  logic [7:0] vec_cnt, err_cnt;
  logic [1:0] first_err_vec;
  logic [2:0] first_err_y;
  logic       busy0, done0, pass0, err_flag0;
  logic [7:0] vec_cnt0, err_cnt0;
  logic [1:0] first_err_vec0;
  logic [2:0] first_err_y0;
  logic       busy3, done3, pass3, err_flag3;
  logic [7:0] vec_cnt3, err_cnt3;
  logic [1:0] first_err_vec3;
  logic [2:0] first_err_y3;

  gate_vector_checker #(.NVEC(4), .SETTLE(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .vld(vld), .a(a), .b(b), .y(y),
    .busy(busy), .done(done), .pass(pass), .vec_cnt(vec_cnt), .err_cnt(err_cnt),
    .err_flag(err_flag), .first_err_vec(first_err_vec), .first_err_y(first_err_y));

  gate_vector_checker #(.NVEC(4), .SETTLE(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .vld(vld0), .a(a), .b(b), .y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .vec_cnt(vec_cnt0), .err_cnt(err_cnt0),
    .err_flag(err_flag0), .first_err_vec(first_err_vec0), .first_err_y(first_err_y0));

  gate_vector_checker #(.NVEC(4), .SETTLE(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .vld(vld3), .a(a), .b(b), .y(y3),
    .busy(busy3), .done(done3), .pass(pass3), .vec_cnt(vec_cnt3), .err_cnt(err_cnt3),
    .err_flag(err_flag3), .first_err_vec(first_err_vec3), .first_err_y(first_err_y3));

  int checks = 0;
  int passes = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 00,01,10,11 with a one-cycle vld every 4 cycles
  task automatic sweep();
    for (int v = 0; v < 4; v++) begin
      {a, b} = v[1:0];
      vld = 1'b1;
      tick();
      vld = 1'b0;
      repeat (3) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    checks++; if ({busy, done, pass, vec_cnt, err_cnt, err_flag, first_err_vec, first_err_y} !== 25'd0)
      $display("FAIL reset_dut: got %h expected 0", {busy, done, pass, vec_cnt, err_cnt, err_flag, first_err_vec, first_err_y}); else passes++;
    checks++; if ({busy0, done0, pass0, vec_cnt0, err_cnt0, err_flag0, first_err_vec0, first_err_y0} !== 25'd0)
      $display("FAIL reset_dut0: got %h expected 0", {busy0, done0, pass0, vec_cnt0, err_cnt0, err_flag0, first_err_vec0, first_err_y0}); else passes++;
    checks++; if ({busy3, done3, pass3, vec_cnt3, err_cnt3, err_flag3, first_err_vec3, first_err_y3} !== 25'd0)
      $display("FAIL reset_dut3: got %h expected 0", {busy3, done3, pass3, vec_cnt3, err_cnt3, err_flag3, first_err_vec3, first_err_y3}); else passes++;
  endtask

  task automatic test_correct();
    stuck = 1'b0;
    start = 1'b1;
    vld   = 1'b1;
    a = 1'b1; b = 1'b1;
    tick();
    start = 1'b0;
    vld   = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL correct_busy_after_start: got %b expected 1", busy); else passes++;
    sweep();
    checks++; if (done !== 1'b1) $display("FAIL correct_done: got %b expected 1", done); else passes++;
    checks++; if (pass !== 1'b1) $display("FAIL correct_pass: got %b expected 1", pass); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL correct_busy: got %b expected 0", busy); else passes++;
    checks++; if (vec_cnt !== 8'd4) $display("FAIL correct_vec_cnt: got %0d expected 4", vec_cnt); else passes++;
    checks++; if (err_cnt !== 8'd0) $display("FAIL correct_err_cnt: got %0d expected 0", err_cnt); else passes++;
    checks++; if (err_flag !== 1'b0) $display("FAIL correct_err_flag: got %b expected 0", err_flag); else passes++;
  endtask

  task automatic test_faulty();
    stuck = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (vec_cnt !== 8'd0 || done !== 1'b0) $display("FAIL faulty_restart: got vec_cnt=%0d done=%b expected 0/0", vec_cnt, done); else passes++;
    sweep();
    checks++; if (err_cnt !== 8'd1) $display("FAIL faulty_err_cnt: got %0d expected 1", err_cnt); else passes++;
    checks++; if (first_err_vec !== 2'b11) $display("FAIL faulty_first_vec: got %b expected 11", first_err_vec); else passes++;
    checks++; if (first_err_y !== 3'b010) $display("FAIL faulty_first_y: got %b expected 010", first_err_y); else passes++;
    checks++; if (pass !== 1'b0) $display("FAIL faulty_pass: got %b expected 0", pass); else passes++;
    checks++; if (done !== 1'b1) $display("FAIL faulty_done: got %b expected 1", done); else passes++;
    checks++; if (err_flag !== 1'b1) $display("FAIL faulty_err_flag: got %b expected 1", err_flag); else passes++;
    checks++; if (vec_cnt !== 8'd4) $display("FAIL faulty_vec_cnt: got %0d expected 4", vec_cnt); else passes++;
    stuck = 1'b0;
  endtask

  task automatic test_back_to_back();
    a = 1'b0; b = 1'b1;
    start = 1'b1;
    vld   = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({err_flag, err_cnt, vec_cnt, first_err_vec, first_err_y} !== 22'd0)
      $display("FAIL b2b_clear: got %h expected 0", {err_flag, err_cnt, vec_cnt, first_err_vec, first_err_y}); else passes++;
    repeat (3) tick();
    checks++; if (vec_cnt !== 8'd0) $display("FAIL b2b_before_first: got %0d expected 0", vec_cnt); else passes++;
    tick();
    checks++; if (vec_cnt !== 8'd1) $display("FAIL b2b_first: got %0d expected 1", vec_cnt); else passes++;
    repeat (11) tick();
    checks++; if (vec_cnt !== 8'd3 || done !== 1'b0) $display("FAIL b2b_third: got vec_cnt=%0d done=%b expected 3/0", vec_cnt, done); else passes++;
    tick();
    checks++; if (vec_cnt !== 8'd4 || done !== 1'b1) $display("FAIL b2b_fourth: got vec_cnt=%0d done=%b expected 4/1", vec_cnt, done); else passes++;
    checks++; if (pass !== 1'b1) $display("FAIL b2b_pass: got %b expected 1", pass); else passes++;
    repeat (4) tick();
    vld = 1'b0;
    checks++; if (vec_cnt !== 8'd4 || done !== 1'b1) $display("FAIL b2b_vld_in_done: got vec_cnt=%0d done=%b expected 4/1", vec_cnt, done); else passes++;
  endtask

  task automatic test_start_in_wait();
    start = 1'b1;
    tick();
    start = 1'b0;
    a = 1'b1; b = 1'b0;
    vld = 1'b1;
    tick();
    vld = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || vec_cnt !== 8'd0) $display("FAIL wait_start_ignored: got busy=%b vec_cnt=%0d expected 1/0", busy, vec_cnt); else passes++;
    repeat (2) tick();
    checks++; if (vec_cnt !== 8'd1 || busy !== 1'b1) $display("FAIL wait_vector_completes: got vec_cnt=%0d busy=%b expected 1/1", vec_cnt, busy); else passes++;
  endtask

  task automatic test_reset_in_check();
    a = 1'b0; b = 1'b0;
    vld = 1'b1;
    tick();
    vld = 1'b0;
    repeat (3) tick();
    a = 1'b1; b = 1'b1;
    vld = 1'b1;
    tick();
    vld = 1'b0;
    repeat (2) tick();
    checks++; if (vec_cnt !== 8'd2 || busy !== 1'b1) $display("FAIL rstchk_pre: got vec_cnt=%0d busy=%b expected 2/1", vec_cnt, busy); else passes++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({busy, done, pass, vec_cnt, err_cnt, err_flag, first_err_vec, first_err_y} !== 25'd0)
      $display("FAIL rstchk_outputs: got %h expected 0", {busy, done, pass, vec_cnt, err_cnt, err_flag, first_err_vec, first_err_y}); else passes++;
    start = 1'b1;
    tick();
    start = 1'b0;
    sweep();
    checks++; if (vec_cnt !== 8'd4 || done !== 1'b1 || pass !== 1'b1)
      $display("FAIL rstchk_resweep: got vec_cnt=%0d done=%b pass=%b expected 4/1/1", vec_cnt, done, pass); else passes++;
  endtask

  task automatic test_latency0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    a = 1'b1; b = 1'b1;
    vld0 = 1'b1;
    tick();
    vld0 = 1'b0;
    checks++; if (vec_cnt0 !== 8'd0) $display("FAIL lat0_at_e0: got %0d expected 0", vec_cnt0); else passes++;
    tick();
    checks++; if (vec_cnt0 !== 8'd1 || err_cnt0 !== 8'd0) $display("FAIL lat0_at_e1: got vec_cnt=%0d err_cnt=%0d expected 1/0", vec_cnt0, err_cnt0); else passes++;
  endtask

  task automatic test_latency3();
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    a = 1'b1; b = 1'b0;
    vld3 = 1'b1;
    tick();
    vld3 = 1'b0;
    glitch3 = 1'b1;
    repeat (3) tick();
    glitch3 = 1'b0;
    checks++; if (vec_cnt3 !== 8'd0 || busy3 !== 1'b1) $display("FAIL lat3_at_e3: got vec_cnt=%0d busy=%b expected 0/1", vec_cnt3, busy3); else passes++;
    tick();
    checks++; if (vec_cnt3 !== 8'd1) $display("FAIL lat3_at_e4: got %0d expected 1", vec_cnt3); else passes++;
    checks++; if (err_cnt3 !== 8'd0 || err_flag3 !== 1'b0) $display("FAIL lat3_glitch: got err_cnt=%0d err_flag=%b expected 0/0", err_cnt3, err_flag3); else passes++;
  endtask

  initial begin
    test_reset();
    test_correct();
    test_faulty();
    test_back_to_back();
    test_start_in_wait();
    test_reset_in_check();
    test_latency0();
    test_latency3();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/gate_vector_checker.md
Name: gate_vector_checker

Overview:
- Downstream consumer of the 3-bit logic-gate block (y[2]=AND, y[1]=OR, y[0]=NOT a).
- Takes each applied (a,b) vector and the gate output y, waits a programmable settle time, then compares y against the expected truth-table value.
- Counts vectors and mismatches, captures the first failing vector, and reports pass/fail when a run of NVEC vectors completes.
- Used as the self-checking back end for gate-level benches and board bring-up.

Parameters:
- NVEC, 4: number of vectors per run. Range 1..2^CNT_W-1.
- SETTLE, 2: cycles to wait between capturing a vector and sampling y. Range 0..15.
- CNT_W, 8: width of vec_cnt and err_cnt. Must satisfy 2^CNT_W > NVEC.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a run; honoured only in IDLE or DONE.
- vld  in  1  a/b carry a new applied vector this cycle.
- a  in  1  applied input a.
- b  in  1  applied input b.
- y  in  3  gate output under check.
- busy  out  1  high in RUN, WAIT and CHECK.
- done  out  1  high in DONE.
- pass  out  1  done && err_cnt==0.
- vec_cnt  out  CW  number of vectors checked this run.
- err_cnt  out  CW  number of mismatching vectors; saturates at all-ones.
- err_flag  out  1  sticky; set on the first mismatch of the run.
- first_err_vec  out  2  {a,b} of the first mismatch.
- first_err_y  out  3  y observed at the first mismatch.

Behaviour:
- Reset (takes precedence over everything, including mid-run):
  - state=IDLE.
  - All outputs 0; capture registers and settle counter 0.
- States:
  - IDLE: start -> clear vec_cnt, err_cnt, err_flag, first_err_*; go to RUN. vld is ignored.
  - RUN: vld=1 at an edge -> capture {a,b} into va/vb. Go to WAIT with settle counter=SETTLE-1, or straight to CHECK if SETTLE=0. vld=0 -> stay in RUN.
  - WAIT: decrement the counter each edge; at 0 go to CHECK. vld and start are ignored.
  - CHECK (exactly one cycle): exp = {va&vb, va|vb, ~va}. At the closing edge:
    - vec_cnt+1.
    - If y!=exp: err_cnt+1 (saturating); if err_flag==0, load first_err_vec={va,vb} and first_err_y=y, then set err_flag.
    - If the new vec_cnt==NVEC go to DONE, else go to RUN.
  - DONE: outputs held stable. start -> same clearing as in IDLE, then go to RUN.
- Timing: a vector captured at edge E0 has y sampled during the cycle ending at edge E0+SETTLE+1. Counters and done/pass update at that same edge.
- Throughput: one vector per SETTLE+2 cycles at most. vld pulses arriving outside RUN are dropped, not queued.
- start while busy is ignored. start and vld together in IDLE: only start acts, and vld is not captured.
- y is sampled only in CHECK; y activity in any other state has no effect.
- pass is combinational from the done register and err_cnt, and is never high outside DONE.

Test Plan:
- Correct gate, SETTLE=2, NVEC=4: start, then vectors 00, 01, 10, 11 each with a 1-cycle vld spaced 4 cycles apart -> done=1, pass=1, vec_cnt=4, err_cnt=0, err_flag=0.
- Faulty gate (y[2] stuck at 0) on the same sweep -> err_cnt=1, first_err_vec=2'b11, first_err_y=3'b010, pass=0, done=1.
- Latency with SETTLE=0: vld at edge E0 -> vec_cnt increments at E0+1. With SETTLE=3 it increments at E0+4; a y glitch injected only during WAIT does not count as an error.
- vld held high continuously from start -> exactly 4 vectors accepted, one per SETTLE+2 cycles, then DONE. Extra vld pulses in DONE leave vec_cnt=4.
- start pulsed in WAIT is ignored (busy stays 1, counters unchanged). start in DONE clears all counters and flags and a second sweep completes with pass=1.
- rst asserted in CHECK after 2 vectors -> next cycle state=IDLE and every output 0. A subsequent start and full sweep gives vec_cnt=4.
